traffic_phase_scheduler: RTL

Sensor-driven phase scheduler for a two-way intersection. It shares the crossing between the north-south and east-west vehicle approaches and a pedestrian walk phase. It owns all signal-head outputs: it decides when each approach gets green, times yellow, all-red and walk intervals, and guarantees the two approaches are never green at the same time.

---
 rtl/traffic_phase_scheduler_if.sv | 30 +++
 rtl/traffic_phase_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler_if.sv
// Sensor and signal-head bundle for the intersection phase scheduler.
// master: the scheduler, which drives the lamps. slave: the field side, which drives the requests.
interface traffic_phase_scheduler_if;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic       ns_green;
  logic       ns_yellow;
  logic       ns_red;
  logic       ew_green;
  logic       ew_yellow;
  logic       ew_red;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    input  ns_req, ew_req, ped_req,
    output ns_green, ns_yellow, ns_red,
    output ew_green, ew_yellow, ew_red,
    output walk, ped_pending, phase
  );

  modport slave (
    output ns_req, ew_req, ped_req,
    input  ns_green, ns_yellow, ns_red,
    input  ew_green, ew_yellow, ew_red,
    input  walk, ped_pending, phase
  );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection scheduler with a pedestrian walk phase.
// Moore lamp decode; green gaps out after MIN_GREEN or maxes out at MAX_GREEN when contested.
module traffic_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 6,
  parameter int unsigned CNT_W     = 5
) (
  input logic                       clk,
  input logic                       rst,
  traffic_phase_scheduler_if.master bus
);

  localparam logic [2:0] StNsGreen  = 3'd0;
  localparam logic [2:0] StNsYellow = 3'd1;
  localparam logic [2:0] StAllRed   = 3'd2;
  localparam logic [2:0] StEwGreen  = 3'd3;
  localparam logic [2:0] StEwYellow = 3'd4;
  localparam logic [2:0] StWalk     = 3'd5;
  localparam logic [2:0] StClear    = 3'd6;

  localparam logic [CNT_W-1:0] MinGreenLast = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MaxGreenLast = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AllredLast   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WalkLast     = CNT_W'(WALK_T - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             last_dir_q, last_dir_d;  // 0 = NS served last, 1 = EW
  logic             ped_pending_q, ped_pending_d;

  logic ns_contest, ew_contest;
  logic ns_exit, ew_exit;
  logic in_green;
  logic enter_walk;

  assign ns_contest = bus.ew_req | ped_pending_q;
  assign ew_contest = bus.ns_req | ped_pending_q;

  // Gap-out once minimum green is served and own approach is empty; max-out regardless.
  assign ns_exit = ((t_q >= MinGreenLast) && ns_contest && !bus.ns_req) ||
                   ((t_q >= MaxGreenLast) && ns_contest);
  assign ew_exit = ((t_q >= MinGreenLast) && ew_contest && !bus.ew_req) ||
                   ((t_q >= MaxGreenLast) && ew_contest);

  assign in_green = (state_q == StNsGreen) || (state_q == StEwGreen);

  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    case (state_q)
      StNsGreen: begin
        if (ns_exit) state_d = StNsYellow;
      end
      StNsYellow: begin
        if (t_q == YellowLast) begin
          state_d    = StAllRed;
          last_dir_d = 1'b0;
        end
      end
      StAllRed: begin
        if (t_q == AllredLast) begin
          if (ped_pending_q)   state_d = StWalk;
          else if (last_dir_q) state_d = StNsGreen;
          else                 state_d = StEwGreen;
        end
      end
      StEwGreen: begin
        if (ew_exit) state_d = StEwYellow;
      end
      StEwYellow: begin
        if (t_q == YellowLast) begin
          state_d    = StAllRed;
          last_dir_d = 1'b1;
        end
      end
      StWalk: begin
        if (t_q == WalkLast) state_d = StClear;
      end
      StClear: begin
        if (t_q == AllredLast) state_d = last_dir_q ? StNsGreen : StEwGreen;
      end
      default: state_d = StAllRed;
    endcase
  end

  // Green timers saturate so an uncontested rest never wraps; other states exit before overflow.
  always_comb begin
    t_d = t_q + 1'b1;
    if (state_d != state_q) begin
      t_d = '0;
    end else if (in_green && (t_q >= MaxGreenLast)) begin
      t_d = MaxGreenLast;
    end
  end

  // Clearing on WALK entry beats a simultaneous button press.
  assign enter_walk = (state_d == StWalk) && (state_q != StWalk);

  always_comb begin
    ped_pending_d = ped_pending_q | bus.ped_req;
    if (enter_walk) ped_pending_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StAllRed;
      t_q           <= '0;
      last_dir_q    <= 1'b1;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      t_q           <= t_d;
      last_dir_q    <= last_dir_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    bus.ns_green    = (state_q == StNsGreen);
    bus.ns_yellow   = (state_q == StNsYellow);
    bus.ns_red      = !((state_q == StNsGreen) || (state_q == StNsYellow));
    bus.ew_green    = (state_q == StEwGreen);
    bus.ew_yellow   = (state_q == StEwYellow);
    bus.ew_red      = !((state_q == StEwGreen) || (state_q == StEwYellow));
    bus.walk        = (state_q == StWalk);
    bus.ped_pending = ped_pending_q;
    bus.phase       = state_q;
  end

endmodule
